// File: rtl/mem_bus_initiator.sv
// Single-outstanding command/response initiator for the native valid/ready memory bus.
// Optional request watchdog enabled by defining MEM_BUS_INITIATOR_TIMEOUT_EN.
module mem_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] rdata_reg, rdata_next;

  // Byte offset bits are discarded: the bus is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[1:0];

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] count_reg, count_next;
  logic        err_reg, err_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      rdata_reg <= '0;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
      count_reg <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      rdata_reg <= rdata_next;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
      count_reg <= count_next;
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    rdata_next = rdata_reg;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    count_next = count_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = {cmd_addr[31:2], 2'b00};
          wdata_next = cmd_wdata;
          wstrb_next = cmd_write ? cmd_wstrb : 4'b0000;
          state_next = REQ;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
          count_next = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ready) begin
          // An all-zero strobe is a read, even if it arrived as a write command.
          rdata_next = (wstrb_reg == 4'b0000) ? mem_rdata : 32'h0;
          state_next = RESP;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
          err_next   = 1'b0;
        end else if (count_reg == LAST_COUNT) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count_reg + 16'd1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so no input reaches an output combinationally.
  assign cmd_ready = (state_reg == IDLE);
  assign mem_valid = (state_reg == REQ);
  assign rsp_valid = (state_reg == RESP);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;
  assign rsp_rdata = rdata_reg;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  assign rsp_err   = err_reg;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench for mem_bus_initiator: vector table, hand sequences, random traffic
// against a word-array model of the memory behind a latency-programmable responder.
`timescale 1ns/1ps
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Responder: registered BRAM-controller style, acknowledges after resp_lat extra wait cycles.
  logic [31:0] bram [16] = '{32'h5, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        rdy_r = 1'b0;
  logic [31:0] rdata_r = 32'h0;
  int          wait_cnt = 0;
  logic        resp_en = 1'b1;
  int          resp_lat = 0;
  logic        inject = 1'b0;

  assign mem_ready = rdy_r | inject;
  assign mem_rdata = inject ? 32'hDEAD_BEEF : rdata_r;

  always @(posedge clk) begin
    if (reset) begin
      rdy_r    <= 1'b0;
      wait_cnt <= 0;
    end else begin
      rdy_r <= 1'b0;
      if (mem_valid && !rdy_r && resp_en) begin
        if (wait_cnt >= resp_lat) begin
          rdy_r    <= 1'b1;
          wait_cnt <= 0;
          rdata_r  <= bram[mem_addr[5:2]];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Reference model: the memory contents as seen from the command side.
  logic [31:0] model_mem [16] = '{32'h5, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic handshake_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // One complete transaction with model-derived checks on bus fields, latency and response.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int lat, input int hold, input logic spur,
                        output logic [31:0] bus_addr, output logic [3:0] bus_strb,
                        output logic [31:0] got_rdata);
    int n;
    int vcycles;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    logic [3:0]  idx;
    exp_strb  = wr ? strb : 4'b0000;
    idx       = addr[5:2];
    exp_rdata = (exp_strb == 4'b0000) ? model_mem[idx] : 32'h0;
    resp_lat  = lat;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 1'b0;
    bus_addr = mem_addr;
    bus_strb = mem_wstrb;
    chk("mem_valid_after_accept", 32'(mem_valid), 32'h1);
    chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
    chk("mem_wdata", mem_wdata, wdata);
    vcycles = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (mem_valid) vcycles++;
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_arrives", 32'(rsp_valid), 32'h1);
    chk("mem_valid_cycles", 32'(vcycles), 32'(lat + 2));
    chk("mem_valid_released", 32'(mem_valid), 32'h0);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'h0);
    got_rdata = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      inject = spur && (i == 1);
      @(negedge clk);
    end
    inject = 1'b0;
    handshake_rsp();
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'h0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'h1);
    if (exp_strb != 4'b0000)
      for (int b = 0; b < 4; b++)
        if (exp_strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    $display("[TB] txn wr=%0b addr=%h wdata=%h strb=%h lat=%0d -> rdata=%h err=%0b",
             wr, addr, wdata, strb, lat, got_rdata, rsp_err);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    int          hold;
    logic        spur;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ba, rd;
    logic [3:0]  bs;
    int          n;
    int          vcycles;

    vecs[0] = '{1'b0, 32'h4, 32'h0,         4'h0, 0, 0, 1'b0, 32'h4, 4'h0, 32'hA};
    vecs[1] = '{1'b0, 32'h0, 32'h0,         4'h0, 2, 0, 1'b0, 32'h0, 4'h0, 32'h5};
    vecs[2] = '{1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, 32'h8, 4'hF, 32'h0};
    vecs[3] = '{1'b0, 32'h8, 32'h0,         4'h0, 1, 0, 1'b0, 32'h8, 4'h0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h7, 32'h0,         4'h0, 0, 5, 1'b1, 32'h4, 4'h0, 32'hA};
    vecs[5] = '{1'b1, 32'hC, 32'h1122_3344, 4'h3, 1, 0, 1'b0, 32'hC, 4'h3, 32'h0};
    vecs[6] = '{1'b1, 32'hE, 32'hFFFF_FFFF, 4'h0, 0, 0, 1'b0, 32'hC, 4'h0, 32'h0000_3344};
    vecs[7] = '{1'b1, 32'h9, 32'hAABB_CCDD, 4'h4, 2, 0, 1'b0, 32'h8, 4'h4, 32'h0};
    vecs[8] = '{1'b0, 32'hB, 32'h0,         4'h0, 3, 0, 1'b0, 32'h8, 4'h0, 32'hCABB_F00D};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);

    // Spurious acknowledge while idle.
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    chk("spur_idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("spur_idle_mem_valid", 32'(mem_valid), 32'h0);
    chk("spur_idle_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].lat,
             vecs[i].hold, vecs[i].spur, ba, bs, rd);
      chk("vec_mem_addr", ba, vecs[i].exp_addr);
      chk("vec_mem_wstrb", 32'(bs), 32'(vecs[i].exp_strb));
      chk("vec_rsp_rdata", rd, vecs[i].exp_rdata);
    end
    @(negedge clk);
    chk("no_extra_rsp", 32'(rsp_valid), 32'h0);

    // Asynchronous reset while a request is outstanding.
    resp_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midreq_mem_valid", 32'(mem_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("post_reset_mem_addr", mem_addr, 32'h0);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 1'b0, ba, bs, rd);
    chk("post_reset_read", rd, 32'h5);

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    // Responder stays silent: watchdog must abort after exactly 8 request cycles.
    resp_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    @(negedge clk);
    cmd_valid = 1'b0;
    vcycles = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (mem_valid) vcycles++;
      @(negedge clk);
      n++;
    end
    chk("timeout_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("timeout_mem_valid_cycles", 32'(vcycles), 32'd8);
    chk("timeout_rsp_err", 32'(rsp_err), 32'h1);
    chk("timeout_rsp_rdata", rsp_rdata, 32'h0);
    chk("timeout_mem_valid_low", 32'(mem_valid), 32'h0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    chk("timeout_late_ack_err", 32'(rsp_err), 32'h1);
    chk("timeout_late_ack_rdata", rsp_rdata, 32'h0);
    chk("timeout_late_ack_valid", 32'(rsp_valid), 32'h1);
    handshake_rsp();
    chk("timeout_rsp_cleared", 32'(rsp_valid), 32'h0);
    $display("[TB] txn timeout read addr=00000004 -> err=1");
    resp_en = 1'b1;
    // Acknowledge lands on the expiry edge: normal completion wins.
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, 6, 0, 1'b0, ba, bs, rd);
    chk("coincident_rdata", rd, 32'hA);
`endif

    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      do_txn(wr, addr, wdata, strb, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), ba, bs, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
